pattern_engine: RTL and testbench

// - Runtime-selectable test-pattern generator for the VGA screensaver pixel path.
// - Sits between the VGA timing counter and the colour output pins.
// - Computes a registered RGB pixel from the look-ahead pixel position.
// - Supports four modes, per-frame scrolling and glitch-free mode switching at frame boundaries.

---
 rtl/pattern_engine.sv | 191 +++++++++++++++++++
 tb/tb_pattern_engine.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_engine.sv
// Test-pattern generator for the VGA pixel path: checker, carpet, scrolling bars, gradient.
// Optional per-frame brightness fade is compiled in when PATTERN_FADE_EN is defined.
module pattern_engine #(
   parameter int SCREEN_WIDTH  = 640,
   parameter int SCREEN_HEIGHT = 480,
   parameter int COLOR_BITS    = 4,
   parameter int TILE_LOG2     = 6,
   parameter int CARPET_LOG2   = 9,
   localparam int XW = $clog2(SCREEN_WIDTH),
   localparam int YW = $clog2(SCREEN_HEIGHT)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [XW-1:0]         position_x_next,
   input  logic [YW-1:0]         position_y_next,
   input  logic [31:0]           frame,
   input  logic [1:0]            mode_req,
   input  logic                  mode_req_valid,
   input  logic [3:0]            scroll_step,
   output logic [1:0]            mode,
   output logic                  mode_ack,
   output logic [COLOR_BITS-1:0] r,
   output logic [COLOR_BITS-1:0] g,
   output logic [COLOR_BITS-1:0] b
);

   localparam int CB     = COLOR_BITS;
   localparam int CSIDE  = 2 ** CARPET_LOG2;
   localparam int X0     = (SCREEN_WIDTH > CSIDE) ? (SCREEN_WIDTH - CSIDE) / 2 : 0;
   localparam int SY_OFF = (CSIDE - SCREEN_HEIGHT) / 2;

   typedef enum logic [1:0] {
      MODE_CHECKER  = 2'd0,
      MODE_CARPET   = 2'd1,
      MODE_BARS     = 2'd2,
      MODE_GRADIENT = 2'd3
   } mode_e;

   // Upper CB bits of the 2*CB-bit product raw*lvl.
   function automatic logic [CB-1:0] fade_scale(input logic [CB-1:0] raw, input logic [CB-1:0] lvl);
      return CB'(({{CB{1'b0}}, raw} * {{CB{1'b0}}, lvl}) >> CB);
   endfunction

   logic [31:0]   frame_q;
   logic [1:0]    mode_q, mode_d;
   logic          ack_q, ack_d;
   logic [1:0]    pend_q, pend_d;
   logic          pend_valid_q, pend_valid_d;
   logic [XW-1:0] scroll_q, scroll_d;
   logic [CB-1:0] r_q, g_q, b_q, r_d, g_d, b_d;
   logic [CB-1:0] raw_r, raw_g, raw_b;
   logic          tick;

   // Control: tick detection, pending request and mode application
   always_comb begin
      tick         = (frame != frame_q);
      mode_d       = mode_q;
      pend_valid_d = pend_valid_q;
      ack_d        = 1'b0;
      scroll_d     = scroll_q;
      pend_d       = mode_req_valid ? mode_req : pend_q;
      if (tick) begin
         scroll_d = scroll_q + XW'(scroll_step);
         if (pend_valid_q) begin
            mode_d       = pend_q;
            pend_valid_d = 1'b0;
            ack_d        = 1'b1;
         end
      end
      // A same-cycle request survives the tick and waits for the next one.
      if (mode_req_valid)
         pend_valid_d = 1'b1;
   end

   // Pattern evaluation on the look-ahead position
   logic [31:0]            x32;
   logic                   carpet_in, carpet_c;
   logic [CARPET_LOG2-1:0] sx, sy;
   logic [XW-1:0]          bar_pos;
   logic                   unused_bits;

   always_comb begin
      x32       = 32'(position_x_next);
      carpet_in = (x32 >= 32'(X0)) && (x32 < 32'(X0 + CSIDE));
      sx        = CARPET_LOG2'(x32 - 32'(X0));
      sy        = CARPET_LOG2'(32'(position_y_next) + 32'(SY_OFF));
      carpet_c  = 1'b1;
      for (int k = CARPET_LOG2 - 1; k >= 2; k -= 2)
         carpet_c = carpet_c & ((sx[k] ^ sx[k-1]) | (sy[k] ^ sy[k-1]));
      bar_pos   = position_x_next + scroll_q;

      raw_r = '0;
      raw_g = '0;
      raw_b = '0;
      case (mode_e'(mode_q))
         MODE_CHECKER: begin
            raw_r = {CB{(position_x_next[TILE_LOG2] ^ position_y_next[TILE_LOG2]) & frame[1]}};
            raw_g = {CB{(position_x_next[TILE_LOG2] ^ position_y_next[TILE_LOG2]) & frame[0]}};
            raw_b = {CB{(position_x_next[TILE_LOG2] ^ position_y_next[TILE_LOG2]) & frame[2]}};
         end
         MODE_CARPET: begin
            raw_r = {CB{carpet_in & carpet_c}};
            raw_g = {CB{carpet_in & carpet_c}};
            raw_b = {CB{carpet_in & carpet_c}};
         end
         MODE_BARS: begin
            raw_r = {CB{bar_pos[TILE_LOG2]}};
            raw_g = {CB{bar_pos[TILE_LOG2+1]}};
            raw_b = {CB{bar_pos[TILE_LOG2+2]}};
         end
         MODE_GRADIENT: begin
            raw_r = position_x_next[XW-1 -: CB];
            raw_g = position_y_next[YW-1 -: CB];
            raw_b = scroll_q[XW-1 -: CB];
         end
         default: ;
      endcase
   end

   assign unused_bits = ^{bar_pos[TILE_LOG2-1:0], bar_pos[XW-1:TILE_LOG2+3]};

`ifdef PATTERN_FADE_EN
   // Triangle-wave brightness: one step per frame, turning at 0 and at full scale.
   logic [CB-1:0] lvl_q, lvl_d;
   logic          dir_up_q, dir_up_d, dir_eff;

   always_comb begin
      dir_eff  = (lvl_q == '0) ? 1'b1 : (lvl_q == '1) ? 1'b0 : dir_up_q;
      lvl_d    = lvl_q;
      dir_up_d = dir_up_q;
      if (tick) begin
         lvl_d    = dir_eff ? lvl_q + 1'b1 : lvl_q - 1'b1;
         dir_up_d = dir_eff;
      end
      r_d = fade_scale(raw_r, lvl_q);
      g_d = fade_scale(raw_g, lvl_q);
      b_d = fade_scale(raw_b, lvl_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lvl_q    <= '1;
         dir_up_q <= 1'b0;
      end else begin
         lvl_q    <= lvl_d;
         dir_up_q <= dir_up_d;
      end
   end
`else
   always_comb begin
      r_d = raw_r;
      g_d = raw_g;
      b_d = raw_b;
   end
`endif

   // Registered outputs and control state
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_q      <= '0;
         mode_q       <= '0;
         ack_q        <= 1'b0;
         pend_valid_q <= 1'b0;
         scroll_q     <= '0;
         r_q          <= '0;
         g_q          <= '0;
         b_q          <= '0;
      end else begin
         frame_q      <= frame;
         mode_q       <= mode_d;
         ack_q        <= ack_d;
         pend_valid_q <= pend_valid_d;
         scroll_q     <= scroll_d;
         r_q          <= r_d;
         g_q          <= g_d;
         b_q          <= b_d;
      end
   end

   // Pending value is only meaningful while pend_valid_q is set.
   always_ff @(posedge clk) begin
      pend_q <= pend_d;
   end

   assign mode     = mode_q;
   assign mode_ack = ack_q;
   assign r        = r_q;
   assign g        = g_q;
   assign b        = b_q;

endmodule

// File: tb/tb_pattern_engine.sv
// Directed bench for pattern_engine; exercises the fade path when PATTERN_FADE_EN is defined.
module tb_pattern_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  position_x_next;
   logic [8:0]  position_y_next;
   logic [31:0] frame;
   logic [1:0]  mode_req;
   logic        mode_req_valid;
   logic [3:0]  scroll_step;
   logic [1:0]  mode;
   logic        mode_ack;
   logic [3:0]  r, g, b;

   int n_assert = 0;
   int n_fail   = 0;

   pattern_engine dut (
      .clk             (clk),
      .rst             (rst),
      .position_x_next (position_x_next),
      .position_y_next (position_y_next),
      .frame           (frame),
      .mode_req        (mode_req),
      .mode_req_valid  (mode_req_valid),
      .scroll_step     (scroll_step),
      .mode            (mode),
      .mode_ack        (mode_ack),
      .r               (r),
      .g               (g),
      .b               (b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_rgb(input string tag, input logic [3:0] er, input logic [3:0] eg, input logic [3:0] eb);
      check({tag, ".r"}, 32'(r), 32'(er));
      check({tag, ".g"}, 32'(g), 32'(eg));
      check({tag, ".b"}, 32'(b), 32'(eb));
   endtask

   initial begin
      rst             = 1'b1;
      position_x_next = '0;
      position_y_next = '0;
      frame           = '0;
      mode_req        = '0;
      mode_req_valid  = 1'b0;
      scroll_step     = '0;
      step();
      step();
      check_rgb("reset", 4'h0, 4'h0, 4'h0);
      check("reset.mode", 32'(mode), 32'd0);
      check("reset.ack", 32'(mode_ack), 32'd0);
      rst = 1'b0;

`ifdef PATTERN_FADE_EN
      // White checker tile; frame low bits stay 3'b111 while upper bits change.
      position_x_next = 10'd64;
      position_y_next = 9'd0;
      frame = 32'd7;
      step();
      step();
      check_rgb("fade_1tick", 4'hD, 4'hD, 4'hD);
      for (int i = 0; i < 14; i++) begin
         frame = frame + 32'd8;
         step();
      end
      step();
      check_rgb("fade_15tick", 4'h0, 4'h0, 4'h0);
      frame = frame + 32'd8;
      step();
      step();
      check("fade_16tick.r", 32'(r), 32'h0);
      frame = frame + 32'd8;
      step();
      step();
      check("fade_17tick.r", 32'(r), 32'h1);
`else
      // Checker, frame=7
      frame = 32'd7;
      position_x_next = 10'd64;
      position_y_next = 9'd0;
      step();
      check_rgb("checker_on", 4'hF, 4'hF, 4'hF);
      check("checker.ack", 32'(mode_ack), 32'd0);
      position_y_next = 9'd64;
      step();
      check_rgb("checker_off", 4'h0, 4'h0, 4'h0);

      // Mid-frame request must wait for the tick
      mode_req = 2'd1;
      mode_req_valid = 1'b1;
      step();
      mode_req_valid = 1'b0;
      step();
      check("midframe.mode", 32'(mode), 32'd0);
      check("midframe.ack", 32'(mode_ack), 32'd0);
      frame = 32'd8;
      step();
      check("tick.mode", 32'(mode), 32'd1);
      check("tick.ack", 32'(mode_ack), 32'd1);

      // Carpet: X0=64, sy=y+16
      position_x_next = 10'd404;
      position_y_next = 9'd0;
      step();
      check("ack_pulse", 32'(mode_ack), 32'd0);
      check_rgb("carpet_404_0", 4'hF, 4'hF, 4'hF);
      position_x_next = 10'd0;
      step();
      check("carpet_0_0.r", 32'(r), 32'h0);
      position_x_next = 10'd100;
      step();
      check("carpet_100_0.r", 32'(r), 32'h0);
      position_x_next = 10'd64;
      position_y_next = 9'd324;
      step();
      check("carpet_64_324.r", 32'(r), 32'hF);
      position_x_next = 10'd63;
      step();
      check("carpet_63_324.r", 32'(r), 32'h0);
      position_x_next = 10'd575;
      step();
      check("carpet_575_324.r", 32'(r), 32'hF);
      position_x_next = 10'd576;
      step();
      check("carpet_576_324.r", 32'(r), 32'h0);

      // Request on the tick cycle is deferred one frame
      mode_req = 2'd2;
      mode_req_valid = 1'b1;
      frame = 32'd9;
      step();
      mode_req_valid = 1'b0;
      check("simul.mode", 32'(mode), 32'd1);
      check("simul.ack", 32'(mode_ack), 32'd0);
      step();
      check("simul_hold.mode", 32'(mode), 32'd1);
      frame = 32'd10;
      step();
      check("simul_next.mode", 32'(mode), 32'd2);
      check("simul_next.ack", 32'(mode_ack), 32'd1);

      // Last request in a frame wins
      mode_req = 2'd2;
      mode_req_valid = 1'b1;
      step();
      mode_req = 2'd3;
      step();
      mode_req_valid = 1'b0;
      frame = 32'd11;
      step();
      check("overwrite.mode", 32'(mode), 32'd3);

      // Gradient: scroll still 0
      position_x_next = 10'h3C0;
      position_y_next = 9'h1A0;
      step();
      check_rgb("gradient", 4'hF, 4'hD, 4'h0);

      // Bars with 70 ticks of step 15 -> scroll 26
      mode_req = 2'd2;
      mode_req_valid = 1'b1;
      step();
      mode_req_valid = 1'b0;
      scroll_step = 4'd15;
      for (int i = 0; i < 70; i++) begin
         frame = frame + 32'd1;
         step();
      end
      check("bars.mode", 32'(mode), 32'd2);
      position_x_next = 10'd38;
      position_y_next = 9'd0;
      step();
      check_rgb("bars_38", 4'hF, 4'h0, 4'h0);
      position_x_next = 10'd997;
      step();
      check_rgb("bars_997", 4'hF, 4'hF, 4'hF);
      position_x_next = 10'd998;
      step();
      check_rgb("bars_998", 4'h0, 4'h0, 4'h0);

      // Reset mid-frame discards the pending request
      mode_req = 2'd1;
      mode_req_valid = 1'b1;
      step();
      mode_req_valid = 1'b0;
      rst = 1'b1;
      step();
      check("midrst.mode", 32'(mode), 32'd0);
      check("midrst.r", 32'(r), 32'h0);
      rst = 1'b0;
      scroll_step = 4'd0;
      step();
      check("postrst.mode", 32'(mode), 32'd0);
      check("postrst.ack", 32'(mode_ack), 32'd0);
      frame = frame + 32'd1;
      step();
      check("postrst_tick.mode", 32'(mode), 32'd0);
      check("postrst_tick.ack", 32'(mode_ack), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
